// File: rtl/hub75_column_driver_if.sv
// hub75_column_driver_if: frame_manager -> HUB75 driver column-pair stream.
// master = frame_manager side, slave = column driver side.
interface hub75_column_driver_if #(
    parameter int unsigned NUM_ROWS  = 64,
    parameter int unsigned SCAN_RATE = 32,
    parameter int unsigned RGB_RES   = 9
) ();
    localparam int unsigned ADDR_W = $clog2(SCAN_RATE);

    logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0] columns;
    logic [ADDR_W-1:0]                     col_num1;
    logic                                  data_valid;
    logic                                  hub75_ready;
    logic                                  hub75_last;

    modport master (
        output columns, col_num1, data_valid,
        input  hub75_ready, hub75_last
    );

    modport slave (
        input  columns, col_num1, data_valid,
        output hub75_ready, hub75_last
    );
endinterface

// File: rtl/hub75_column_driver.sv
// hub75_column_driver: captures one upper/lower column pair and drives it onto a HUB75 panel as BCM bit planes.
// Build option HUB75_BLANK_EN: adds BLANK_CYC OE-high guard cycles before and after every latch pulse.
module hub75_column_driver #(
    parameter int unsigned NUM_ROWS  = 64,
    parameter int unsigned SCAN_RATE = 32,
    parameter int unsigned RGB_RES   = 9,
    parameter int unsigned BASE_ON   = 8,
    parameter int unsigned BLANK_CYC = 4
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    hub75_column_driver_if.slave         stream,
    output logic [2:0]                   rgb1_out,
    output logic [2:0]                   rgb2_out,
    output logic [$clog2(SCAN_RATE)-1:0] addr_out,
    output logic                         sclk_out,
    output logic                         latch_out,
    output logic                         oe_n_out
);
    localparam int unsigned PLANES  = RGB_RES / 3;
    localparam int unsigned PLANE_W = (PLANES > 1) ? $clog2(PLANES) : 1;
    localparam int unsigned PIX_W   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int unsigned IDX_W   = $clog2(RGB_RES);
    localparam int unsigned ADDR_W  = $clog2(SCAN_RATE);
    localparam int unsigned MAX_ON  = BASE_ON << (PLANES - 1);
    localparam int unsigned CNT_MAX = (MAX_ON > BLANK_CYC) ? MAX_ON : BLANK_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE, SHIFT, LATCH, DISPLAY, DONE, BLANK_PRE, BLANK_POST
    } state_t;

    // state names the cycle about to be emitted; every output is loaded on the edge that enters it
    state_t                                state;
    logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0] cols_q;
    logic [ADDR_W-1:0]                     col_q;
    logic [PLANE_W-1:0]                    plane;
    logic [PIX_W-1:0]                      pix;
    logic                                  ph;
    logic [CNT_W-1:0]                      cnt;
    logic                                  ready_q;
    logic                                  last_q;

    logic [CNT_W-1:0] on_last_c;
    logic             last_plane_c;
    logic             last_pix_c;
    logic [2:0]       bits_up_c;
    logic [2:0]       bits_lo_c;

    assign stream.hub75_ready = ready_q;
    assign stream.hub75_last  = last_q;

    // R, G, B bits of one pixel for the active plane
    function automatic logic [2:0] plane_bits(input logic [RGB_RES-1:0] px,
                                              input logic [PLANE_W-1:0] b);
        logic [IDX_W-1:0] bi;
        bi = IDX_W'(b);
        return {px[IDX_W'(2 * PLANES) + bi], px[IDX_W'(PLANES) + bi], px[bi]};
    endfunction

    assign on_last_c    = (CNT_W'(BASE_ON) << plane) - CNT_W'(1);
    assign last_plane_c = (plane == PLANE_W'(PLANES - 1));
    assign last_pix_c   = (pix == PIX_W'(NUM_ROWS - 1));
    assign bits_up_c    = plane_bits(cols_q[0][pix], plane);
    assign bits_lo_c    = plane_bits(cols_q[1][pix], plane);

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state     <= IDLE;
            ready_q   <= 1'b0;
            last_q    <= 1'b0;
            rgb1_out  <= '0;
            rgb2_out  <= '0;
            addr_out  <= '0;
            sclk_out  <= 1'b0;
            latch_out <= 1'b0;
            oe_n_out  <= 1'b1;
            cols_q    <= '0;
            col_q     <= '0;
            plane     <= '0;
            pix       <= '0;
            ph        <= 1'b0;
            cnt       <= '0;
        end else begin
            last_q    <= 1'b0;
            latch_out <= 1'b0;
            case (state)
                IDLE: begin
                    rgb1_out <= '0;
                    rgb2_out <= '0;
                    sclk_out <= 1'b0;
                    oe_n_out <= 1'b1;
                    if (ready_q && stream.data_valid) begin
                        cols_q  <= stream.columns;
                        col_q   <= stream.col_num1;
                        ready_q <= 1'b0;
                        plane   <= '0;
                        pix     <= '0;
                        ph      <= 1'b0;
                        state   <= SHIFT;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                SHIFT: begin
                    oe_n_out <= 1'b1;
                    ph       <= ~ph;
                    if (!ph) begin
                        rgb1_out <= bits_up_c;
                        rgb2_out <= bits_lo_c;
                        sclk_out <= 1'b0;
                    end else begin
                        sclk_out <= 1'b1;
                        cnt      <= '0;
                        if (last_pix_c) begin
`ifdef HUB75_BLANK_EN
                            state <= BLANK_PRE;
`else
                            state <= LATCH;
`endif
                        end else begin
                            pix <= pix + PIX_W'(1);
                        end
                    end
                end
`ifdef HUB75_BLANK_EN
                BLANK_PRE: begin
                    rgb1_out <= '0;
                    rgb2_out <= '0;
                    sclk_out <= 1'b0;
                    oe_n_out <= 1'b1;
                    cnt      <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(BLANK_CYC - 1)) begin
                        cnt   <= '0;
                        state <= LATCH;
                    end
                end
                BLANK_POST: begin
                    rgb1_out <= '0;
                    rgb2_out <= '0;
                    sclk_out <= 1'b0;
                    oe_n_out <= 1'b1;
                    cnt      <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(BLANK_CYC - 1)) begin
                        cnt   <= '0;
                        state <= DISPLAY;
                    end
                end
`endif
                LATCH: begin
                    rgb1_out  <= '0;
                    rgb2_out  <= '0;
                    sclk_out  <= 1'b0;
                    oe_n_out  <= 1'b1;
                    latch_out <= 1'b1;
                    addr_out  <= col_q;
                    cnt       <= '0;
`ifdef HUB75_BLANK_EN
                    state     <= BLANK_POST;
`else
                    state     <= DISPLAY;
`endif
                end
                DISPLAY: begin
                    rgb1_out <= '0;
                    rgb2_out <= '0;
                    sclk_out <= 1'b0;
                    oe_n_out <= 1'b0;
                    cnt      <= cnt + CNT_W'(1);
                    if (cnt == on_last_c) begin
                        cnt <= '0;
                        if (last_plane_c) begin
                            state <= DONE;
                        end else begin
                            plane <= plane + PLANE_W'(1);
                            pix   <= '0;
                            ph    <= 1'b0;
                            state <= SHIFT;
                        end
                    end
                end
                DONE: begin
                    rgb1_out <= '0;
                    rgb2_out <= '0;
                    sclk_out <= 1'b0;
                    oe_n_out <= 1'b1;
                    last_q   <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hub75_column_driver.sv
// tb_hub75_column_driver: directed vector table plus randomized pairs, checked cycle by cycle
// against a timeline model built from the plane/pixel timing rules.
module tb_hub75_column_driver;
    localparam int N    = 64;
    localparam int BASE = 8;
`ifdef HUB75_BLANK_EN
    localparam int BL       = 4;
    localparam int PAIR_LEN = 468;
`else
    localparam int BL       = 0;
    localparam int PAIR_LEN = 444;
`endif
    localparam int FIRST_LATCH = 1 + 2 * N + BL;
    localparam int STOP_T      = 1 + (2 * N + 2 * BL + 1 + BASE) + 2 * 30;

    typedef logic [1:0][N-1:0][8:0] pair_t;
    typedef struct packed {
        logic       ready;
        logic       last;
        logic [2:0] rgb1;
        logic [2:0] rgb2;
        logic [4:0] addr;
        logic       sclk;
        logic       latch;
        logic       oe_n;
    } obs_t;
    typedef struct {
        int             pix;
        logic [8:0]     up_val;
        logic [8:0]     lo_val;
        logic [4:0]     col;
        logic [2:0][2:0] e1;
        logic [2:0][2:0] e2;
    } vec_t;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic [2:0] rgb1, rgb2;
    logic [4:0] addr;
    logic       sclk, latch, oe_n;

    int         checks = 0;
    int         errors = 0;
    logic [4:0] addr_model;
    logic [2:0] rise1[$];
    logic [2:0] rise2[$];
    logic [4:0] latch_q[$];
    int         oe_runs[$];
    int         last_t;
    vec_t       vecs[4];
    int         exp_on[3];

    hub75_column_driver_if #(.NUM_ROWS(N), .SCAN_RATE(32), .RGB_RES(9)) bus ();

    hub75_column_driver dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .stream    (bus),
        .rgb1_out  (rgb1),
        .rgb2_out  (rgb2),
        .addr_out  (addr),
        .sclk_out  (sclk),
        .latch_out (latch),
        .oe_n_out  (oe_n)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o = {bus.hub75_ready, bus.hub75_last, rgb1, rgb2, addr, sclk, latch, oe_n};
        return o;
    endfunction

    function automatic obs_t rst_obs(input logic rdy);
        obs_t o;
        o       = '0;
        o.oe_n  = 1'b1;
        o.ready = rdy;
        return o;
    endfunction

    function automatic pair_t rand_pair();
        pair_t c;
        for (int h = 0; h < 2; h++)
            for (int p = 0; p < N; p++)
                c[h][p] = 9'($urandom);
        return c;
    endfunction

    // Expected pins t cycles after the capture edge, from plane lengths and pixel order
    function automatic obs_t model(input int t, input pair_t c, input logic [4:0] col,
                                   input logic [4:0] prev);
        obs_t       o;
        int         rem, len;
        bit         found;
        logic [8:0] pu, pl;
        o      = '0;
        o.oe_n = 1'b1;
        o.addr = (t >= FIRST_LATCH) ? col : prev;
        if (t == PAIR_LEN) o.last = 1'b1;
        else if (t == PAIR_LEN + 1) o.ready = 1'b1;
        else if (t >= 1 && t < PAIR_LEN) begin
            rem   = t - 1;
            found = 1'b0;
            for (int b = 0; b < 3; b++) begin
                len = 2 * N + 2 * BL + 1 + (BASE << b);
                if (!found && rem < len) begin
                    found = 1'b1;
                    if (rem < 2 * N) begin
                        pu     = c[0][6'(rem / 2)] >> b;
                        pl     = c[1][6'(rem / 2)] >> b;
                        o.rgb1 = {pu[6], pu[3], pu[0]};
                        o.rgb2 = {pl[6], pl[3], pl[0]};
                        o.sclk = (rem % 2 == 1);
                    end else if (rem == 2 * N + BL) begin
                        o.latch = 1'b1;
                    end else if (rem >= 2 * N + 2 * BL + 1) begin
                        o.oe_n = 1'b0;
                    end
                end else if (!found) begin
                    rem -= len;
                end
            end
        end
        return o;
    endfunction

    // Offer a pair, follow it through the driver and compare every cycle with the model
    task automatic send(input pair_t c, input logic [4:0] col, input bit hold, input bit junk,
                        input int stop_t);
        int   waited, run, bad_t;
        bit   bad;
        obs_t got, exp, bad_got, bad_exp;
        bus.columns    = c;
        bus.col_num1   = col;
        bus.data_valid = 1'b1;
        waited = 0;
        while (bus.hub75_ready !== 1'b1 && waited < 2000) begin
            @(negedge clk_in);
            waited++;
        end
        if (waited >= 2000) begin
            checks++;
            errors++;
            $display("FAIL ready_wait col=%0d: got ready=%b required 1 within 2000 cycles", col, bus.hub75_ready);
            bus.data_valid = 1'b0;
            return;
        end
        @(posedge clk_in);
        rise1.delete(); rise2.delete(); latch_q.delete(); oe_runs.delete();
        last_t = -1;
        run    = 0;
        bad    = 1'b0;
        bad_t  = 0;
        bad_got = '0;
        bad_exp = '0;
        for (int t = 0; t <= PAIR_LEN + 1; t++) begin
            @(negedge clk_in);
            got = sample();
            exp = model(t, c, col, addr_model);
            if (got !== exp && !bad) begin
                bad = 1'b1; bad_t = t; bad_got = got; bad_exp = exp;
            end
            if (got.sclk) begin
                rise1.push_back(got.rgb1);
                rise2.push_back(got.rgb2);
            end
            if (got.latch) latch_q.push_back(got.addr);
            if (got.oe_n == 1'b0) run++;
            else if (run > 0) begin
                oe_runs.push_back(run);
                run = 0;
            end
            if (got.last && last_t < 0) last_t = t;
            if (t == stop_t) break;
            if (junk && t <= PAIR_LEN) begin
                bus.columns[1'($urandom)][6'($urandom)] = 9'($urandom);
                bus.col_num1   = 5'($urandom);
                bus.data_valid = 1'($urandom);
            end else if (!hold) begin
                bus.data_valid = 1'b0;
            end
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL trace col=%0d t=%0d: got %h required %h", col, bad_t, bad_got, bad_exp);
        end
        if (stop_t < 0) addr_model = col;
    endtask

    initial begin
        pair_t c;
        int    nz;
        vecs[0] = '{pix: 0,  up_val: 9'h1FF, lo_val: 9'h000, col: 5'd5,
                    e1: {3'b111, 3'b111, 3'b111}, e2: 9'h000};
        vecs[1] = '{pix: 10, up_val: 9'b100_010_001, lo_val: 9'h000, col: 5'd7,
                    e1: {3'b100, 3'b010, 3'b001}, e2: 9'h000};
        vecs[2] = '{pix: 63, up_val: 9'h000, lo_val: 9'b001_100_010, col: 5'd31,
                    e1: 9'h000, e2: {3'b010, 3'b001, 3'b100}};
        vecs[3] = '{pix: 32, up_val: 9'b110_101_011, lo_val: 9'b011_110_101, col: 5'd0,
                    e1: {3'b110, 3'b101, 3'b011}, e2: {3'b011, 3'b110, 3'b101}};
        exp_on = '{8, 16, 32};

        // reset held with valid data offered
        rst_in         = 1'b0;
        addr_model     = '0;
        bus.columns    = rand_pair();
        bus.col_num1   = 5'd17;
        bus.data_valid = 1'b1;
        repeat (5) begin
            @(negedge clk_in);
            check("reset_hold", 32'(sample()), 32'(rst_obs(1'b0)));
        end
        rst_in = 1'b1;
        @(negedge clk_in);
        check("release_ready", 32'(sample()), 32'(rst_obs(1'b1)));
        bus.data_valid = 1'b0;
        nz = 0;
        repeat (8) begin
            @(negedge clk_in);
            if (sample() !== rst_obs(1'b1)) nz++;
        end
        check("idle_no_capture", 32'(nz), 32'd0);

        // directed single-pixel vectors
        for (int i = 0; i < 4; i++) begin
            c = '0;
            c[0][vecs[i].pix] = vecs[i].up_val;
            c[1][vecs[i].pix] = vecs[i].lo_val;
            send(c, vecs[i].col, 1'b0, 1'b0, -1);
            check($sformatf("v%0d_rise_count", i), 32'(rise1.size()), 32'(3 * N));
            for (int b = 0; b < 3; b++) begin
                check($sformatf("v%0d_rgb1_plane%0d", i, b), 32'(rise1[b * N + vecs[i].pix]), 32'(vecs[i].e1[b]));
                check($sformatf("v%0d_rgb2_plane%0d", i, b), 32'(rise2[b * N + vecs[i].pix]), 32'(vecs[i].e2[b]));
                check($sformatf("v%0d_oe_low_plane%0d", i, b), 32'(oe_runs[b]), 32'(exp_on[b]));
            end
            nz = 0;
            for (int k = 0; k < rise1.size(); k++)
                if (k % N != vecs[i].pix && (rise1[k] | rise2[k]) != 3'b000) nz++;
            check($sformatf("v%0d_other_pixels_zero", i), 32'(nz), 32'd0);
            check($sformatf("v%0d_latch_count", i), 32'(latch_q.size()), 32'd3);
            check($sformatf("v%0d_latch_addr", i), 32'(latch_q[0]), 32'(vecs[i].col));
            check($sformatf("v%0d_oe_runs", i), 32'(oe_runs.size()), 32'd3);
            check($sformatf("v%0d_last_cycle", i), 32'(last_t), 32'(PAIR_LEN));
        end

        // random pairs with junk offered on the bus while busy
        for (int i = 0; i < 6; i++) begin
            send(rand_pair(), 5'($urandom), 1'b0, 1'b1, -1);
            check($sformatf("rand%0d_latch_count", i), 32'(latch_q.size()), 32'd3);
        end

        // continuous valid, address walk with wrap
        for (int k = 0; k <= 32; k++) begin
            send(rand_pair(), 5'(k % 32), 1'b1, 1'b0, -1);
            check($sformatf("cont%0d_latch_count", k), 32'(latch_q.size()), 32'd3);
            check($sformatf("cont%0d_latch_addr", k), 32'(latch_q[0]), 32'(k % 32));
        end
        bus.data_valid = 1'b0;

        // reset while shifting plane 1 pixel 30
        send(rand_pair(), 5'd9, 1'b0, 1'b0, STOP_T);
        check("midreset_latches_before", 32'(latch_q.size()), 32'd1);
        rst_in = 1'b0;
        @(negedge clk_in);
        check("midreset_outputs", 32'(sample()), 32'(rst_obs(1'b0)));
        @(negedge clk_in);
        check("midreset_hold", 32'(sample()), 32'(rst_obs(1'b0)));
        rst_in     = 1'b1;
        addr_model = '0;
        @(negedge clk_in);
        check("midreset_release", 32'(sample()), 32'(rst_obs(1'b1)));
        send(rand_pair(), 5'd22, 1'b0, 1'b0, -1);
        check("restart_latch_addr", 32'(latch_q[0]), 32'd22);
        check("restart_last_cycle", 32'(last_t), 32'(PAIR_LEN));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
